// File: rtl/router_pkt_tx.sv
// router_pkt_tx
//
// Packet source for one router input port. A command (address, length,
// parity-error flag) is accepted in IDLE. The block then drives a header byte
// {len, addr}, len payload bytes popped from a first-word-fall-through buffer,
// and finally a parity byte. The parity byte is the XOR of the header and all
// payload bytes, optionally complemented for error injection. Every byte is
// held on the pins until the router consumes it, which is a rising edge with
// busy low.
//
// Ports
//   clk, rst        clock; synchronous active-low reset
//   cmd_valid       command request
//   cmd_ready       high only in IDLE (combinational from state)
//   cmd_addr[1:0]   destination port 0..2; 3 is rejected with an err pulse
//   cmd_len[5:0]    payload byte count 0..63
//   cmd_bad_parity  send the complemented parity byte
//   pl_data[7:0]    head of the payload buffer
//   pl_empty        payload buffer empty
//   pl_rd           payload pop strobe (combinational)
//   busy            router busy; a byte is consumed at an edge with busy low
//   abort           drop the current packet (ignored in IDLE)
//   pkt_valid       registered, to the router
//   data_out[7:0]   registered, to the router data_in
//   done            one-cycle pulse after the parity byte is consumed
//   err             one-cycle pulse after a rejected command
//   pkt_count[15:0] completed packet count, wraps
module router_pkt_tx #(
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_addr,
  input  logic [5:0]  cmd_len,
  input  logic        cmd_bad_parity,
  input  logic [7:0]  pl_data,
  input  logic        pl_empty,
  output logic        pl_rd,
  input  logic        busy,
  input  logic        abort,
  output logic        pkt_valid,
  output logic [7:0]  data_out,
  output logic        done,
  output logic        err,
  output logic [15:0] pkt_count
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_PLD  = 3'd2,
    ST_PAR  = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  // The gap counter only needs to reach GAP_CYCLES-1; keep it at least 1 bit wide.
  localparam int unsigned GAP_W = (GAP_CYCLES > 32'd1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST =
    (GAP_CYCLES > 32'd0) ? GAP_W'(GAP_CYCLES - 32'd1) : {GAP_W{1'b0}};

  // Header byte layout: length in the upper six bits, port in the lower two.
  function automatic logic [7:0] hdr_byte(input logic [5:0] len, input logic [1:0] addr);
    return {len, addr};
  endfunction

  // Byte actually transmitted in the parity slot (optionally corrupted).
  function automatic logic [7:0] tx_parity(input logic [7:0] par, input logic bad);
    return par ^ {8{bad}};
  endfunction

  state_t           state_q, state_d;
  logic             pkt_valid_q, pkt_valid_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [15:0]      pkt_count_q, pkt_count_d;
  logic [7:0]       parity_q, parity_d;
  logic [5:0]       remaining_q, remaining_d;
  logic             bad_par_q, bad_par_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             load_s;

  assign cmd_ready = (state_q == ST_IDLE);
  // The pop strobe must stay low while reset is asserted.
  assign pl_rd     = load_s & rst;
  assign pkt_valid = pkt_valid_q;
  assign data_out  = data_out_q;
  assign done      = done_q;
  assign err       = err_q;
  assign pkt_count = pkt_count_q;

  // Next-state and next-output computation for the packet sequencer.
  always_comb begin
    state_d     = state_q;
    pkt_valid_d = pkt_valid_q;
    data_out_d  = data_out_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    pkt_count_d = pkt_count_q;
    parity_d    = parity_q;
    remaining_d = remaining_q;
    bad_par_d   = bad_par_q;
    gap_cnt_d   = gap_cnt_q;
    load_s      = 1'b0;

    if (abort && (state_q != ST_IDLE)) begin
      // Drop the packet outright; bytes already popped are not restored.
      state_d     = ST_IDLE;
      pkt_valid_d = 1'b0;
      data_out_d  = 8'h00;
      gap_cnt_d   = {GAP_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (cmd_addr == 2'd3) begin
              err_d = 1'b1;
            end else begin
              state_d     = ST_HDR;
              pkt_valid_d = 1'b1;
              data_out_d  = hdr_byte(cmd_len, cmd_addr);
              parity_d    = hdr_byte(cmd_len, cmd_addr);
              remaining_d = cmd_len;
              bad_par_d   = cmd_bad_parity;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end

        // Header and payload share the advance rule: the byte on the pins is
        // replaced only at a consuming edge, and only if a successor exists.
        ST_HDR, ST_PLD: begin
          if (!busy) begin
            if (remaining_q == 6'd0) begin
              state_d     = ST_PAR;
              pkt_valid_d = 1'b0;
              data_out_d  = tx_parity(parity_q, bad_par_q);
            end else if (!pl_empty) begin
              load_s      = 1'b1;
              state_d     = ST_PLD;
              data_out_d  = pl_data;
              parity_d    = parity_q ^ pl_data;
              remaining_d = remaining_q - 6'd1;
            end else begin
              // Buffer underrun: hold the current byte and pkt_valid.
              state_d = state_q;
            end
          end else begin
            state_d = state_q;
          end
        end

        ST_PAR: begin
          if (!busy) begin
            done_d      = 1'b1;
            pkt_count_d = pkt_count_q + 16'd1;
            gap_cnt_d   = {GAP_W{1'b0}};
            if (GAP_CYCLES == 32'd0) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_GAP;
            end
          end else begin
            state_d = ST_PAR;
          end
        end

        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_d   = ST_IDLE;
            gap_cnt_d = {GAP_W{1'b0}};
          end else begin
            gap_cnt_d = gap_cnt_q + {{(GAP_W-1){1'b0}}, 1'b1};
          end
        end

        default: begin
          state_d     = ST_IDLE;
          pkt_valid_d = 1'b0;
          data_out_d  = 8'h00;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      pkt_valid_q <= 1'b0;
      data_out_q  <= 8'h00;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      pkt_count_q <= 16'd0;
      parity_q    <= 8'h00;
      remaining_q <= 6'd0;
      bad_par_q   <= 1'b0;
      gap_cnt_q   <= {GAP_W{1'b0}};
    end else begin
      state_q     <= state_d;
      pkt_valid_q <= pkt_valid_d;
      data_out_q  <= data_out_d;
      done_q      <= done_d;
      err_q       <= err_d;
      pkt_count_q <= pkt_count_d;
      parity_q    <= parity_d;
      remaining_q <= remaining_d;
      bad_par_q   <= bad_par_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: a byte-stream model of each packet
// is compared against the pins on every falling edge, plus literal checks.
module tb_router_pkt_tx;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_addr = 2'd0;
  logic [5:0]  cmd_len = 6'd0;
  logic        cmd_bad_parity = 1'b0;
  logic [7:0]  pl_data;
  logic        pl_empty;
  logic        pl_rd;
  logic        busy = 1'b0;
  logic        abort = 1'b0;
  logic        pkt_valid;
  logic [7:0]  data_out;
  logic        done;
  logic        err;
  logic [15:0] pkt_count;

  router_pkt_tx #(.GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_bad_parity(cmd_bad_parity),
    .pl_data(pl_data), .pl_empty(pl_empty), .pl_rd(pl_rd), .busy(busy),
    .abort(abort), .pkt_valid(pkt_valid), .data_out(data_out), .done(done),
    .err(err), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  // Payload buffer model (first-word-fall-through).
  logic [7:0] pl_mem [0:255];
  logic [7:0] rd_ptr = 8'd0;
  logic [7:0] wr_ptr = 8'd0;
  logic       hold_empty = 1'b0;
  logic       flush_req = 1'b0;
  logic       take;
  assign pl_empty = (rd_ptr == wr_ptr) || hold_empty;
  assign pl_data  = pl_mem[rd_ptr];

  initial begin
    forever begin
      @(negedge clk);
      take = pl_rd;
      @(posedge clk);
      #1;
      if (flush_req) rd_ptr = wr_ptr;
      else if (take) rd_ptr = rd_ptr + 8'd1;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Packet model: queue of bytes still to appear on the pins.
  typedef struct packed { logic pv; logic pld; logic [7:0] data; } item_t;
  item_t       exp_q[$];
  logic [15:0] exp_count = 16'd0;
  logic        exp_done = 1'b0;
  logic        exp_err = 1'b0;
  logic        exp_zero = 1'b1;
  int          gap_left = 0;
  logic [7:0]  cap [0:255];
  int          cap_n = 0;
  int          done_n = 0;
  int          err_n = 0;
  int          prd_n = 0;
  logic        nxt_pld, cons;
  logic [7:0]  hdr, par, b, idx;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      chk("pkt_valid", 16'(pkt_valid), 16'(exp_q[0].pv));
      chk("data_out", 16'(data_out), 16'(exp_q[0].data));
    end else begin
      chk("pkt_valid_idle", 16'(pkt_valid), 16'd0);
      if (exp_zero) chk("data_out_zero", 16'(data_out), 16'd0);
    end
    chk("done", 16'(done), 16'(exp_done));
    chk("err", 16'(err), 16'(exp_err));
    chk("pkt_count", pkt_count, exp_count);
    chk("cmd_ready", 16'(cmd_ready), 16'((exp_q.size() == 0) && (gap_left == 0)));
    if (done) done_n++;
    if (err) err_n++;
    if (pl_rd) prd_n++;

    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (!rst) begin
      chk("pl_rd_reset", 16'(pl_rd), 16'd0);
      exp_q.delete();
      exp_count = 16'd0;
      gap_left  = 0;
      exp_zero  = 1'b1;
    end else if (abort && ((exp_q.size() > 0) || (gap_left > 0))) begin
      chk("pl_rd_abort", 16'(pl_rd), 16'd0);
      exp_q.delete();
      gap_left = 0;
      exp_zero = 1'b1;
    end else if (exp_q.size() > 0) begin
      nxt_pld = (exp_q.size() > 1) && exp_q[1].pld;
      cons = !busy && (!nxt_pld || !pl_empty);
      chk("pl_rd", 16'(pl_rd), 16'(cons && nxt_pld));
      if (cons) begin
        cap[cap_n[7:0]] = data_out;
        cap_n++;
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          exp_done  = 1'b1;
          exp_count = exp_count + 16'd1;
          gap_left  = GAP;
        end
      end
    end else begin
      chk("pl_rd_idle", 16'(pl_rd), 16'd0);
      if (gap_left > 0) begin
        gap_left--;
      end else if (cmd_valid) begin
        if (cmd_addr == 2'd3) begin
          exp_err = 1'b1;
        end else begin
          hdr = {cmd_len, cmd_addr};
          par = hdr;
          exp_q.push_back({1'b1, 1'b0, hdr});
          for (int i = 0; i < int'(cmd_len); i++) begin
            idx = rd_ptr + 8'(i);
            b = pl_mem[idx];
            par = par ^ b;
            exp_q.push_back({1'b1, 1'b1, b});
          end
          exp_q.push_back({1'b0, 1'b0, par ^ {8{cmd_bad_parity}}});
          exp_zero = 1'b0;
        end
      end
    end
  end

  task automatic push_pl(input logic [7:0] v);
    pl_mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic send_cmd(input logic [1:0] a, input logic [5:0] l, input logic bp);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    cmd_addr = a;
    cmd_len = l;
    cmd_bad_parity = bp;
    cmd_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL cmd_accept_timeout: cmd_ready never high within 100 cycles");
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle_timeout: cmd_ready still low after 300 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  // Compare n captured bytes starting at base with bytes[39:32], [31:24], ...
  task automatic chk_bytes(input string name, input int base, input int n, input logic [39:0] bytes);
    for (int i = 0; i < n; i++) begin
      chk(name, 16'(cap[8'(base + i)]), 16'(bytes[39 - 8*i -: 8]));
    end
    chk({name, "_len"}, 16'(cap_n - base), 16'(n));
  endtask

  task automatic flush_pl();
    flush_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    flush_req = 1'b0;
  endtask

  int c0, p0, d0, e0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("reset_pkt_count", pkt_count, 16'd0);
    chk("reset_cmd_ready", 16'(cmd_ready), 16'd1);
    @(posedge clk);
    #1;

    // Basic packet
    push_pl(8'hA5); push_pl(8'h3C); push_pl(8'h0F);
    c0 = cap_n; p0 = prd_n; d0 = done_n;
    send_cmd(2'd1, 6'd3, 1'b0);
    wait_idle();
    chk_bytes("pkt1_bytes", c0, 5, {8'h0D, 8'hA5, 8'h3C, 8'h0F, 8'h9B});
    chk("pkt1_pl_rd", 16'(prd_n - p0), 16'd3);
    chk("pkt1_done", 16'(done_n - d0), 16'd1);
    chk("pkt1_count", pkt_count, 16'd1);

    // Zero-length packet
    c0 = cap_n; p0 = prd_n;
    send_cmd(2'd2, 6'd0, 1'b0);
    wait_idle();
    chk_bytes("pkt2_bytes", c0, 2, {8'h02, 8'h02, 24'h0});
    chk("pkt2_pl_rd", 16'(prd_n - p0), 16'd0);
    chk("pkt2_count", pkt_count, 16'd2);

    // Error-injected parity
    push_pl(8'hFF);
    c0 = cap_n;
    send_cmd(2'd0, 6'd1, 1'b1);
    wait_idle();
    chk_bytes("pkt3_bytes", c0, 3, {8'h04, 8'hFF, 8'h04, 16'h0});
    chk("pkt3_count", pkt_count, 16'd3);

    // Busy on the header, buffer underrun mid-payload
    push_pl(8'hA5); push_pl(8'h3C); push_pl(8'h0F);
    c0 = cap_n;
    busy = 1'b1;
    send_cmd(2'd1, 6'd3, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("stall_hdr_held", 16'(data_out), 16'h000D);
      @(posedge clk);
      #1;
    end
    busy = 1'b0;
    @(posedge clk);
    #1;
    hold_empty = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    hold_empty = 1'b0;
    wait_idle();
    chk_bytes("pkt4_bytes", c0, 5, {8'h0D, 8'hA5, 8'h3C, 8'h0F, 8'h9B});
    chk("pkt4_count", pkt_count, 16'd4);

    // Illegal address
    e0 = err_n;
    send_cmd(2'd3, 6'd5, 1'b0);
    @(negedge clk);
    chk("err_pulse", 16'(err), 16'd1);
    chk("err_cmd_ready", 16'(cmd_ready), 16'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("err_once", 16'(err_n - e0), 16'd1);

    // Abort on the second payload byte
    push_pl(8'h11); push_pl(8'h22); push_pl(8'h33); push_pl(8'h44); push_pl(8'h55);
    d0 = done_n;
    send_cmd(2'd0, 6'd5, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    abort = 1'b1;
    @(negedge clk);
    chk("abort_byte", 16'(data_out), 16'h0022);
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_pkt_valid", 16'(pkt_valid), 16'd0);
    chk("abort_data", 16'(data_out), 16'd0);
    chk("abort_idle", 16'(cmd_ready), 16'd1);
    chk("abort_count", pkt_count, 16'd4);
    flush_pl();
    chk("abort_no_done", 16'(done_n - d0), 16'd0);

    // Reset mid-packet
    push_pl(8'h61); push_pl(8'h62); push_pl(8'h63); push_pl(8'h64); push_pl(8'h65);
    send_cmd(2'd2, 6'd5, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_pkt_valid", 16'(pkt_valid), 16'd0);
    chk("rst_data", 16'(data_out), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_count", pkt_count, 16'd0);
    chk("rst_ready", 16'(cmd_ready), 16'd1);
    flush_pl();

    // Recovery packet after reset
    push_pl(8'h01); push_pl(8'h80);
    c0 = cap_n;
    send_cmd(2'd1, 6'd2, 1'b0);
    wait_idle();
    chk_bytes("pkt5_bytes", c0, 4, {8'h09, 8'h01, 8'h80, 8'h88, 8'h00});
    chk("pkt5_count", pkt_count, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Packet source for the router's input port. It takes a packet command of address and length. It pulls payload bytes from a first-word-fall-through buffer and drives the router's `pkt_valid`/`data_in` pins: header byte, then payload bytes, then parity byte. It holds each byte while the router's `busy` is high. It is used as the on-chip traffic generator and as the bench driver model for router integration.

## Interface
- `GAP_CYCLES`, default 2: minimum idle cycles after a parity byte before the next command is accepted; 0 is legal.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE (combinational from state).
- `cmd_addr`  in  2  destination port, 0..2; the value 3 is illegal.
- `cmd_len`  in  6  payload byte count, 0..63.
- `cmd_bad_parity`  in  1  send the complemented parity byte (error injection).
- `pl_data`  in  8  head of the payload buffer, valid whenever the buffer is non-empty.
- `pl_empty`  in  1  payload buffer empty.
- `pl_rd`  out  1  pop strobe; combinational.
- `busy`  in  1  router busy; a byte is consumed at any rising edge where `busy`=0.
- `abort`  in  1  drop the current packet.
- `pkt_valid`  out  1  to the router; registered.
- `data_out`  out  8  to the router `data_in`; registered.
- `done`  out  1  one-cycle pulse when a packet's parity byte is consumed.
- `err`  out  1  one-cycle pulse when a command is rejected.
- `pkt_count`  out  16  count of completed packets; wraps 0xFFFF->0.

## Operation
- Header byte = {cmd_len, cmd_addr}.
- Parity = XOR of the header and all payload bytes.
- Transmitted parity byte = parity ^ {8{cmd_bad_parity}}, with `cmd_bad_parity` latched at command accept.
- States:
  - IDLE: `pkt_valid`=0, `cmd_ready`=1.
  - HDR: `pkt_valid`=1, `data_out`=header.
  - PLD: `pkt_valid`=1, `data_out`=payload byte.
  - PAR: `pkt_valid`=0, `data_out`=parity byte.
  - GAP: `pkt_valid`=0.
- Command accept happens when `cmd_valid`&`cmd_ready`:
  - If `cmd_addr`=3: pulse `err`, stay in IDLE, emit nothing.
  - Otherwise: latch addr, len and bad_parity, load the header into `data_out`, init the parity register to the header, set `remaining`=len, go to HDR.
- The state advances only on a consuming edge (`busy`=0). Before HDR->PLD or PLD->PLD it also requires `pl_empty`=0.
  - While `pl_empty`=1, hold the current byte and `pkt_valid`. This is a stall, not a bubble.
- On a payload load: `pl_rd`=1 in that cycle, `data_out`<=`pl_data`, parity^=`pl_data`, `remaining`-=1.
- HDR with len=0 goes directly to PAR, with no `pl_rd`.
- PLD consumed with `remaining`=0 goes to PAR: `pkt_valid` drops and `data_out` takes the parity byte.
- PAR consumed: `done`=1 next cycle, `pkt_count`+=1, then go to GAP. With `GAP_CYCLES`=0 it goes straight to IDLE.
- GAP counts `GAP_CYCLES` cycles, then goes to IDLE.
- `abort` (any state except IDLE):
  - Next state IDLE, `pkt_valid`=0, `data_out`=0.
  - No `done`, no count increment, no `pl_rd` in that cycle.
  - Already-popped bytes are not restored.
- Abort in IDLE is ignored. If `abort` and `cmd_valid` are high together in IDLE, the command is accepted normally.
- Reset (`rst`=0 at an edge): state IDLE, `pkt_valid`=0, `data_out`=0x00, `done`=0, `err`=0, `pkt_count`=0, parity register=0, gap counter=0.
  - Reset overrides abort and command accept.
  - `pl_rd`=0 while `rst`=0.

## Timing
- Command accept edge -> header on the pins the next cycle: 1-cycle latency.
- Each byte stays on `data_out` until the first edge with `busy`=0. The byte is replaced at that same edge.
- With `busy`=0 and payload available: one byte per cycle. A packet of length L occupies L+2 cycles of pins, plus `GAP_CYCLES`, plus 1 IDLE cycle before the next header.
- `pkt_valid` falls on the same edge the parity byte appears. It never rises again before the GAP/IDLE states have elapsed.
- `done` and the `pkt_count` update coincide: the cycle after the PAR-consuming edge.
- `busy` high for N cycles on the header delays the first payload byte by exactly N cycles. No byte is skipped or duplicated.

## Test plan
- addr=1, len=3, payload A5,3C,0F, `busy`=0 -> `data_out` 0D,A5,3C,0F,9B; `pkt_valid` 1,1,1,1,0; three `pl_rd` pulses; `done` once; `pkt_count`=1.
- addr=2, len=0 -> header 0x02, then parity 0x02 with `pkt_valid`=0; no `pl_rd`.
- addr=0, len=1, payload FF, `cmd_bad_parity`=1 -> 04, FF, then 04 (complement of FB).
- `busy` held high 3 cycles while the header is on the pins, `pl_empty`=1 for 2 cycles mid-payload -> each byte held unchanged for the stall; byte sequence identical to the unstalled case.
- `cmd_addr`=3 -> one `err` pulse; `pkt_valid` stays 0; `cmd_ready` stays 1.
- `abort` on the 2nd payload byte of len=5 -> next cycle IDLE, `pkt_valid`=0, no `done`, `pkt_count` unchanged. Reset driven mid-packet -> all outputs at their reset values after one edge.
